uart_tx_periph: RTL and testbench
=================================

UART_TX_PERIPH -- requirements
Module: uart_tx_periph

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, transmit FIFO depth in bytes; SHALL be a power of two, 2..64.
REQ-002 Parameter DIV_RESET, default 434, reset value of the baud divisor (50 MHz / 115200).
REQ-003 sys_clk  in  1  single clock; all state changes on the rising edge.
REQ-004 sys_resetn  in  1  asynchronous, active-low reset.
REQ-005 reg_read  in  1  one-cycle read enable from the system address decoder.
REQ-006 reg_write  in  1  one-cycle write enable from the system address decoder.
REQ-007 reg_addr  in  2  register select: 0 DATA (write-only), 1 STATUS (read, write-1-to-clear), 2 DIV (read/write), 3 reserved.
REQ-008 wstrb  in  4  byte write strobes, bit n qualifies wdata[8n+7:8n].
REQ-009 wdata  in  32  CPU write data.
REQ-010 rdata  out  32  registered read data.
REQ-011 tx  out  1  serial output, idle high.
REQ-012 irq_empty  out  1  high while the FIFO is empty and the shifter is idle.

Function
REQ-013 DATA write with wstrb[0]=1 SHALL push wdata[7:0] when count<FIFO_DEPTH, or when a pop occurs in the same cycle; otherwise the byte is dropped and overflow sets.
REQ-014 DATA write with wstrb[0]=0 SHALL have no effect.
REQ-015 STATUS read value: [0] full, [1] empty, [2] busy (FSM not IDLE), [3] overflow (sticky), [15:8] FIFO count, all other bits 0.
REQ-016 STATUS write with wdata[3]=1 and wstrb[0]=1 SHALL clear overflow; if the same cycle also sets overflow, set wins.
REQ-017 DIV holds 16 bits; wstrb[0]/wstrb[1] update [7:0]/[15:8]; read returns {16'd0, DIV}.
REQ-018 rdata SHALL update on the edge where reg_read=1 and hold otherwise; DATA and reserved reads return 0.
REQ-019 FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
REQ-020 IDLE with the FIFO non-empty SHALL pop one byte and enter START on the same edge; tx drives low from the next cycle.
REQ-021 Each bit SHALL last exactly max(DIV,1) cycles; the bit counter reloads from DIV at every bit boundary, so a DIV change takes effect from the next bit.
REQ-022 DATA SHALL send 8 bits LSB first; then STOP, high for one bit time; then IDLE, or a back-to-back START if the FIFO is non-empty (no extra idle cycle).
REQ-023 Frame length SHALL be 10×DIV cycles (11×DIV with parity).
REQ-024 tx SHALL be registered and glitch-free; it is high in IDLE and STOP.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; the FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-026 With sys_resetn low: tx=1, FSM=IDLE, FIFO empty (pointers 0, count 0), overflow=0, DIV=DIV_RESET, rdata=0, irq_empty=1.
REQ-027 Reset mid-frame SHALL abort the frame immediately, drive tx high asynchronously, and discard all queued bytes.

Configuration
REQ-028 With UART_TX_PARITY_EN defined, the PARITY state SHALL insert an even-parity bit (XOR of the 8 data bits) between DATA and STOP, lasting one bit time.
REQ-029 Without UART_TX_PARITY_EN, no PARITY state or logic SHALL exist and frames SHALL be 8N1.

Verification
REQ-030 DIV=4, write DATA=0x55 -> tx low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4; busy high for 40 cycles; irq_empty returns to 1.
REQ-031 DIV=1000, write 9 bytes back-to-back -> first byte popped, remaining 8 queued, STATUS count=8, full=1, overflow=0; 10th write -> overflow=1, byte dropped; STATUS write 0x8 -> overflow=0.
REQ-032 DIV=2, write 0x01 then 0x80 -> two 20-cycle frames with no idle gap; the second frame's bit 7 is high.
REQ-033 Assert sys_resetn low at cycle 15 of a DIV=4 frame with 3 bytes queued -> tx=1 immediately; after release, STATUS=0x00000002 and DIV reads 434.
REQ-034 With UART_TX_PARITY_EN defined, DIV=4, write 0x07 -> 44-cycle frame with parity bit 1; write 0x03 -> parity bit 0.
REQ-035 DIV=0, write 0xA5 -> each bit lasts 1 cycle, frame is 10 cycles.

Source files
------------

// File: rtl/uart_tx_periph_if.sv
// Register bus between the system address decoder and uart_tx_periph.
interface uart_tx_periph_if;
    // reg_read/reg_write are single-cycle strobes qualified by reg_addr; there is no
    // back-pressure, every access completes on the edge it is sampled and rdata is valid
    // from the cycle after a read strobe until the next one.
    logic        reg_read;
    logic        reg_write;
    logic [1:0]  reg_addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output reg_read, reg_write, reg_addr, wstrb, wdata, input rdata);
    modport slave  (input reg_read, reg_write, reg_addr, wstrb, wdata, output rdata);
endinterface

// File: rtl/uart_tx_periph.sv
// Register-mapped UART transmitter (8N1) with a byte FIFO and programmable baud divisor.
// Defining UART_TX_PARITY_EN adds an even-parity bit, giving 8E1 frames.
module uart_tx_periph #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_RESET  = 434
) (
    input  logic            sys_clk,
    input  logic            sys_resetn,
    uart_tx_periph_if.slave bus,
    output logic            tx,
    output logic            irq_empty,
    output logic [2:0]      fsm_state
);
    localparam int AW = $clog2(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;
`else
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4} state_t;
`endif

    state_t        state, state_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          overflow;
    logic [15:0]   div, cnt, bit_len;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg;
    logic          fifo_full, fifo_empty, busy;
    logic          push_req, push, pop, ovf_set, ovf_clr;
    logic          bit_done, reload, tx_n;
    logic [31:0]   status_val;

    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign busy       = (state != IDLE);
    assign irq_empty  = fifo_empty && !busy;
    assign fsm_state  = state;

    assign bit_len  = (div == 16'd0) ? 16'd1 : div;
    assign bit_done = (cnt == 16'd1);

    assign push_req = bus.reg_write && (bus.reg_addr == 2'd0) && bus.wstrb[0];
    // A full FIFO still accepts a byte when the shifter takes one on the same edge.
    assign push     = push_req && (!fifo_full || pop);
    assign ovf_set  = push_req && !push;
    assign ovf_clr  = bus.reg_write && (bus.reg_addr == 2'd1) && bus.wstrb[0] && bus.wdata[3];

    always_comb begin
        status_val        = 32'd0;
        status_val[0]     = fifo_full;
        status_val[1]     = fifo_empty;
        status_val[2]     = busy;
        status_val[3]     = overflow;
        status_val[15:8]  = 8'(count);
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: if (bit_done) state_n = DATA;
            DATA: begin
                if (bit_done && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_done) state_n = STOP;
`endif
            STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        reload    = pop || (busy && bit_done);
        bit_idx_n = (state == DATA && bit_done) ? bit_idx + 3'd1 : bit_idx;
        // tx is computed from the next state so the registered line changes on the bit edge.
        case (state_n)
            START:  tx_n = 1'b0;
            DATA:   tx_n = shreg[bit_idx_n];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_n = ^shreg;
`endif
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state   <= IDLE;
            tx      <= 1'b1;
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
        end else begin
            state   <= state_n;
            tx      <= tx_n;
            bit_idx <= bit_idx_n;
            if (pop) shreg <= mem[rd_ptr];
            if (reload)    cnt <= bit_len;
            else if (busy) cnt <= cnt - 16'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= bus.wdata[7:0];
    end

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            overflow <= 1'b0;
            div      <= 16'(DIV_RESET);
            bus.rdata <= 32'd0;
        end else begin
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
            if (bus.reg_write && bus.reg_addr == 2'd2) begin
                if (bus.wstrb[0]) div[7:0]  <= bus.wdata[7:0];
                if (bus.wstrb[1]) div[15:8] <= bus.wdata[15:8];
            end
            if (bus.reg_read) begin
                case (bus.reg_addr)
                    2'd1:    bus.rdata <= status_val;
                    2'd2:    bus.rdata <= {16'd0, div};
                    default: bus.rdata <= 32'd0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph: waveform-level reference model plus literal frame checks.
module tb_uart_tx_periph;
    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    // ---------------- clock / reset ----------------
    logic       sys_clk = 1'b0;
    logic       sys_resetn = 1'b0;
    logic       tx, irq_empty;
    logic [2:0] fsm_state;

    uart_tx_periph_if bus();

    uart_tx_periph #(.FIFO_DEPTH(DEPTH), .DIV_RESET(434)) dut (
        .sys_clk    (sys_clk),
        .sys_resetn (sys_resetn),
        .bus        (bus.slave),
        .tx         (tx),
        .irq_empty  (irq_empty),
        .fsm_state  (fsm_state)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_wave holds the expected tx level for the current cycle onward, one entry per cycle.
    logic [7:0]  exp_q[$];
    bit          m_wave[$];
    logic        m_ovf;
    logic [15:0] m_div;
    logic [31:0] m_rdata;

    task automatic add_frame(input logic [7:0] b, input logic [15:0] d);
        int  n;
        bit  seq[$];
        n = (d == 16'd0) ? 1 : int'(d);
        seq.push_back(1'b0);
        for (int i = 0; i < 8; i++) seq.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        seq.push_back(^b);
`endif
        seq.push_back(1'b1);
        foreach (seq[i]) for (int k = 0; k < n; k++) m_wave.push_back(seq[i]);
    endtask

    always @(posedge sys_clk or negedge sys_resetn) begin
        int          cnt_pre;
        bit          busy_pre, do_pop, push_req;
        logic [7:0]  b;
        if (!sys_resetn) begin
            exp_q.delete();
            m_wave.delete();
            m_ovf   = 1'b0;
            m_div   = 16'd434;
            m_rdata = 32'd0;
        end else begin
            cnt_pre  = exp_q.size();
            busy_pre = (m_wave.size() != 0);
            if (bus.reg_read) begin
                case (bus.reg_addr)
                    2'd1: m_rdata = {16'd0, 8'(cnt_pre), 4'd0, m_ovf, busy_pre,
                                     cnt_pre == 0, cnt_pre == DEPTH};
                    2'd2: m_rdata = {16'd0, m_div};
                    default: m_rdata = 32'd0;
                endcase
            end
            do_pop = (cnt_pre != 0) && (m_wave.size() <= 1);
            if (m_wave.size() != 0) void'(m_wave.pop_front());
            if (do_pop) begin
                b = exp_q.pop_front();
                add_frame(b, m_div);
            end
            push_req = bus.reg_write && bus.reg_addr == 2'd0 && bus.wstrb[0];
            if (push_req) begin
                if (cnt_pre < DEPTH || do_pop) exp_q.push_back(bus.wdata[7:0]);
                else m_ovf = 1'b1;
            end
            if (!(push_req && !(cnt_pre < DEPTH || do_pop)) &&
                bus.reg_write && bus.reg_addr == 2'd1 && bus.wstrb[0] && bus.wdata[3])
                m_ovf = 1'b0;
            if (bus.reg_write && bus.reg_addr == 2'd2) begin
                if (bus.wstrb[0]) m_div[7:0]  = bus.wdata[7:0];
                if (bus.wstrb[1]) m_div[15:8] = bus.wdata[15:8];
            end
        end
    end

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge sys_clk) begin
        if (sys_resetn) begin
            check("tx", tx, (m_wave.size() != 0) ? m_wave[0] : 1'b1);
            check("irq_empty", irq_empty, (m_wave.size() == 0) && (exp_q.size() == 0));
            check("rdata", bus.rdata, m_rdata);
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic wr(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d);
        bus.reg_write = 1'b1;
        bus.reg_addr  = a;
        bus.wstrb     = s;
        bus.wdata     = d;
        @(negedge sys_clk);
        bus.reg_write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.reg_read = 1'b1;
        bus.reg_addr = a;
        @(negedge sys_clk);
        bus.reg_read = 1'b0;
        d = bus.rdata;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (irq_empty !== 1'b1 && t < 5000) begin
            @(negedge sys_clk);
            t++;
        end
        check("idle_reached", t < 5000, 1);
    endtask

    // Waits for the start bit, then records n consecutive tx samples (one per cycle).
    task automatic capture(input int n, output logic [63:0] v);
        int t = 0;
        v = '0;
        while (tx !== 1'b0 && t < 3000) begin
            @(negedge sys_clk);
            t++;
        end
        check("start_seen", t < 3000, 1);
        for (int k = 0; k < n; k++) begin
            v[k] = tx;
            @(negedge sys_clk);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] d;
    logic [63:0] v;

    initial begin
        bus.reg_read  = 1'b0;
        bus.reg_write = 1'b0;
        bus.reg_addr  = 2'd0;
        bus.wstrb     = 4'd0;
        bus.wdata     = 32'd0;
        repeat (3) @(negedge sys_clk);
        check("reset_tx", tx, 1);
        check("reset_irq", irq_empty, 1);
        check("reset_rdata", bus.rdata, 0);
        sys_resetn = 1'b1;
        @(negedge sys_clk);
        rd(2'd1, d); check("status_after_reset", d, 32'h2);
        rd(2'd2, d); check("div_after_reset", d, 434);

        // DIV=4, 0x55
        wr(2'd2, 4'b0011, 32'd4);
        wr(2'd0, 4'b0001, 32'h55);
        capture(NBITS * 4, v);
`ifdef UART_TX_PARITY_EN
        check("frame_55", v, 64'hF00F0F0F0F0);
`else
        check("frame_55", v, 64'hF0F0F0F0F0);
`endif
        check("irq_after_55", irq_empty, 1);

        // DIV=0 acts as 1 cycle per bit
        wr(2'd2, 4'b0011, 32'd0);
        wr(2'd0, 4'b0001, 32'hA5);
        capture(NBITS, v);
`ifndef UART_TX_PARITY_EN
        check("frame_a5_div0", v, 64'h34A);
`endif
        check("irq_after_a5", irq_empty, 1);

        // DIV=2, back-to-back frames
        wr(2'd2, 4'b0011, 32'd2);
        wr(2'd0, 4'b0001, 32'h01);
        wr(2'd0, 4'b0001, 32'h80);
        capture(NBITS * 4, v);
        check("b2b_bit7", v[NBITS * 2 + 17], 1);
`ifndef UART_TX_PARITY_EN
        check("b2b_frames", v, 64'hF0000C000C);
`endif
        check("irq_after_b2b", irq_empty, 1);

`ifdef UART_TX_PARITY_EN
        wr(2'd2, 4'b0011, 32'd4);
        wr(2'd0, 4'b0001, 32'h07);
        capture(44, v);
        check("parity_07", v[37], 1);
        check("irq_after_07", irq_empty, 1);
        wr(2'd0, 4'b0001, 32'h03);
        capture(44, v);
        check("parity_03", v[37], 0);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: wr(2'd0, {3'b0, ($urandom_range(0, 5) != 0)}, $urandom);
                5: rd(2'($urandom_range(0, 3)), d);
                6: wr(2'd1, 4'($urandom_range(0, 15)), $urandom);
                7: wr(2'd3, 4'hF, $urandom);
                8: begin
                    wait_idle();
                    wr(2'd2, 4'b0011, 32'($urandom_range(0, 6)));
                end
                default: repeat ($urandom_range(1, 20)) @(negedge sys_clk);
            endcase
        end
        wait_idle();

        // DIV=1000: fill, overflow, clear
        wr(2'd2, 4'b0011, 32'd1000);
        for (int i = 0; i < 9; i++) wr(2'd0, 4'b0001, 32'($urandom_range(0, 255)));
        rd(2'd1, d); check("status_full", d, 32'h805);
        wr(2'd0, 4'b0001, 32'h3C);
        rd(2'd1, d); check("status_overflow", d, 32'h80D);
        wr(2'd1, 4'b0001, 32'h8);
        rd(2'd1, d); check("status_ovf_cleared", d, 32'h805);

        // reset mid-frame at DIV=4 with 3 bytes queued
        wr(2'd2, 4'b0011, 32'd4);
        #2 sys_resetn = 1'b0;
        @(negedge sys_clk);
        sys_resetn = 1'b1;
        wr(2'd2, 4'b0011, 32'd4);
        for (int i = 0; i < 4; i++) wr(2'd0, 4'b0001, 32'h00);
        capture(15, v);
        check("tx_low_before_reset", tx, 0);
        #2 sys_resetn = 1'b0;
        #1;
        check("tx_async_reset", tx, 1);
        check("irq_async_reset", irq_empty, 1);
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_resetn = 1'b1;
        rd(2'd1, d); check("status_post_reset", d, 32'h2);
        rd(2'd2, d); check("div_post_reset", d, 434);
        repeat (5) @(negedge sys_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
